debug_readout_sequencer: RTL and testbench
==========================================

Name: debug_readout_sequencer

Overview:
- Data-side sequencer for the debug path.
- Accepts one-cycle request-select IDs from the MicroBlaze/MIPS debug interface.
- Reads the selected source (register file, PC, data memory, instruction memory or one of 8 pipeline latch groups) and streams a fixed-length strip of 32-bit frames, then a one-cycle end-of-data (EOD) pulse.
- Sits between the debug interface (its o_request_select / o_mem_addr / o_instr_addr outputs) and the MIPS core read ports; drives the interface's i_frame_from_mips and i_eod inputs.

Parameters:
- NB_FRAME, 32, width of one streamed frame and of every source word.
- NB_ADDR_DATA, 16, data memory address width.
- NB_INSTR_ADDR, 9, instruction memory address width.
- NB_STRIP_WORDS, 3, frames per strip (fixed for every request).
- NB_LATCH_GROUP, NB_STRIP_WORDS*NB_FRAME, bits per latch group (derived; must not be overridden).

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_request_select  in  6  request ID; 6'h3F = no request
- i_mem_addr  in  NB_ADDR_DATA  data memory address for ID 6'h20
- i_instr_addr  in  NB_INSTR_ADDR  instruction memory address for ID 6'h21
- o_reg_addr  out  5  register file debug read address
- o_reg_re  out  1  register file debug read strobe
- i_reg_data  in  NB_FRAME  register read data, 1-cycle latency
- o_dmem_addr  out  NB_ADDR_DATA  data memory debug address
- o_dmem_re  out  1  data memory debug read strobe
- i_dmem_data  in  NB_FRAME  data memory read data, 1-cycle latency
- o_imem_addr  out  NB_INSTR_ADDR  instruction memory debug address
- o_imem_re  out  1  instruction memory debug read strobe
- i_imem_data  in  NB_FRAME  instruction memory read data, 1-cycle latency
- i_pc  in  NB_FRAME  current PC
- i_latch_bus  in  8*NB_LATCH_GROUP  flattened latch groups; group k at [(k+1)*NB_LATCH_GROUP-1 : k*NB_LATCH_GROUP]
- o_frame  out  NB_FRAME  streamed frame
- o_frame_valid  out  1  o_frame holds a strip word
- o_eod  out  1  end-of-data pulse
- o_busy  out  1  request in progress

Behaviour:
- ID map:
  - 6'h00–6'h1F: register n = ID[4:0].
  - 6'h20: data memory. 6'h21: instruction memory. 6'h22: PC.
  - 6'h24–6'h2B: latch group k = ID − 6'h24 (fetch data/ctrl, deco data/ctrl, exec data/ctrl, mem data/ctrl).
  - All other IDs except 6'h3F are invalid.
- FSM states: IDLE, FETCH, LOAD, STREAM, EOD.
- IDLE:
  - i_request_select != 6'h3F → capture ID, i_mem_addr and i_instr_addr; go to FETCH.
  - i_request_select is ignored in every state other than IDLE; no queueing.
- FETCH (1 cycle):
  - Drive o_reg_addr/o_dmem_addr/o_imem_addr from the captured values.
  - Pulse only the strobe matching the ID class. PC, latch and invalid IDs pulse no strobe.
- LOAD (1 cycle): fill the strip buffer (NB_STRIP_WORDS words).
  - Register/memory: word0 = i_*_data; remaining words = 0.
  - PC: word0 = i_pc; remaining words = 0. i_pc is sampled in LOAD, not at request.
  - Latch group: word0 = group MSB 32 bits, word1 = next 32 bits, and so on.
  - Invalid ID: buffer not loaded; skip STREAM, go directly to EOD.
- STREAM (NB_STRIP_WORDS cycles):
  - o_frame_valid = 1; o_frame = word i in the i-th STREAM cycle.
  - Word counter wraps to 0 at NB_STRIP_WORDS−1 → EOD.
- EOD (1 cycle): o_eod = 1, o_frame = 0, o_frame_valid = 0; then IDLE.
- Timing: request accepted in cycle T → words in T+3 .. T+2+NB_STRIP_WORDS → o_eod in T+3+NB_STRIP_WORDS.
  - Invalid ID: o_eod at T+3.
  - o_busy = 1 from T+1 through the EOD cycle inclusive.
- o_frame = 0 whenever o_frame_valid = 0.
- Address outputs hold their captured values outside FETCH; strobes are 0 outside FETCH.
- Reset values: o_frame 0, o_frame_valid 0, o_eod 0, o_busy 0, all strobes 0, all addresses 0, FSM IDLE, buffer 0.
- Reset mid-operation: return to IDLE next cycle. No o_eod and no further frames for the aborted request.
- Simultaneous i_reset and request: reset wins; request dropped.
- A request presented in the same cycle the FSM returns from EOD to IDLE is not seen; it is accepted only if still present in an IDLE cycle.

Test Plan:
- Reset then ID 6'h05 with i_reg_data=32'hDEADBEEF: o_reg_re=1 and o_reg_addr=5 at T+1; frames DEADBEEF, 0, 0 at T+3..T+5; o_eod at T+6; o_busy high T+1..T+6.
- ID 6'h24 with group0 = 96'h111111112222222233333333: frames 11111111, 22222222, 33333333 in order, then o_eod.
- ID 6'h20, i_mem_addr=16'h0040, i_dmem_data=32'hCAFE0001: o_dmem_re one cycle with o_dmem_addr=16'h0040; o_imem_re and o_reg_re stay 0; frames CAFE0001, 0, 0.
- ID 6'h2C (invalid): no strobes, o_frame_valid never asserted, o_eod at T+3, o_busy T+1..T+3.
- ID 6'h22 issued, then ID 6'h07 at T+2: only the PC strip is emitted; no register read occurs; o_busy low after EOD.
- i_reset asserted at T+4 during a latch-group strip: all outputs 0 at T+5; no o_eod; a new request 6'h01 afterwards completes normally.

Source files
------------

// File: rtl/debug_readout_sequencer.sv
// Debug readout sequencer: fetches one debug source per request and
// streams it as a fixed-length strip of frames followed by an EOD pulse.
module debug_readout_sequencer #(
    parameter int NB_FRAME       = 32,
    parameter int NB_ADDR_DATA   = 16,
    parameter int NB_INSTR_ADDR  = 9,
    parameter int NB_STRIP_WORDS = 3
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic [5:0]                            i_request_select,
    input  logic [NB_ADDR_DATA-1:0]               i_mem_addr,
    input  logic [NB_INSTR_ADDR-1:0]              i_instr_addr,
    output logic [4:0]                            o_reg_addr,
    output logic                                  o_reg_re,
    input  logic [NB_FRAME-1:0]                   i_reg_data,
    output logic [NB_ADDR_DATA-1:0]               o_dmem_addr,
    output logic                                  o_dmem_re,
    input  logic [NB_FRAME-1:0]                   i_dmem_data,
    output logic [NB_INSTR_ADDR-1:0]              o_imem_addr,
    output logic                                  o_imem_re,
    input  logic [NB_FRAME-1:0]                   i_imem_data,
    input  logic [NB_FRAME-1:0]                   i_pc,
    input  logic [8*NB_STRIP_WORDS*NB_FRAME-1:0]  i_latch_bus,
    output logic [NB_FRAME-1:0]                   o_frame,
    output logic                                  o_frame_valid,
    output logic                                  o_eod,
    output logic                                  o_busy
);

    localparam int NB_LATCH_GROUP = NB_STRIP_WORDS * NB_FRAME;
    localparam int NB_CNT = (NB_STRIP_WORDS > 1) ? $clog2(NB_STRIP_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STREAM,
        S_EOD
    } state_t;

    state_t                     r_state;
    logic [5:0]                 r_id;
    logic [NB_CNT-1:0]          r_cnt;
    logic [NB_LATCH_GROUP-1:0]  r_buf;
    logic [4:0]                 r_reg_addr;
    logic [NB_ADDR_DATA-1:0]    r_dmem_addr;
    logic [NB_INSTR_ADDR-1:0]   r_imem_addr;
    logic                       r_reg_re;
    logic                       r_dmem_re;
    logic                       r_imem_re;
    logic [NB_FRAME-1:0]        r_frame;
    logic                       r_frame_valid;
    logic                       r_eod;
    logic                       r_busy;

    logic                       w_req_reg;
    logic                       w_req_dmem;
    logic                       w_req_imem;
    logic                       w_id_reg;
    logic                       w_id_dmem;
    logic                       w_id_imem;
    logic                       w_id_pc;
    logic                       w_id_latch;
    logic                       w_id_valid;
    logic [2:0]                 w_k;
    logic [NB_LATCH_GROUP-1:0]  w_group;
    logic [NB_LATCH_GROUP-1:0]  w_load;

    assign w_req_reg  = ~i_request_select[5];
    assign w_req_dmem = (i_request_select == 6'h20);
    assign w_req_imem = (i_request_select == 6'h21);

    assign w_id_reg   = ~r_id[5];
    assign w_id_dmem  = (r_id == 6'h20);
    assign w_id_imem  = (r_id == 6'h21);
    assign w_id_pc    = (r_id == 6'h22);
    assign w_id_latch = (r_id >= 6'h24) && (r_id <= 6'h2B);
    assign w_id_valid = w_id_reg | w_id_dmem | w_id_imem | w_id_pc | w_id_latch;

    assign w_k     = 3'(r_id - 6'h24);
    assign w_group = i_latch_bus[w_k*NB_LATCH_GROUP +: NB_LATCH_GROUP];

    // Strip word i lives at bits [i*NB_FRAME +: NB_FRAME]; latch MSBs go out first.
    always_comb begin
        w_load = '0;
        case (1'b1)
            w_id_reg:  w_load[NB_FRAME-1:0] = i_reg_data;
            w_id_dmem: w_load[NB_FRAME-1:0] = i_dmem_data;
            w_id_imem: w_load[NB_FRAME-1:0] = i_imem_data;
            w_id_pc:   w_load[NB_FRAME-1:0] = i_pc;
            w_id_latch: begin
                for (int i = 0; i < NB_STRIP_WORDS; i++) begin
                    w_load[i*NB_FRAME +: NB_FRAME] =
                        w_group[NB_LATCH_GROUP-1-i*NB_FRAME -: NB_FRAME];
                end
            end
            default: w_load = '0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_id          <= 6'h3F;
            r_cnt         <= '0;
            r_buf         <= '0;
            r_reg_addr    <= '0;
            r_dmem_addr   <= '0;
            r_imem_addr   <= '0;
            r_reg_re      <= 1'b0;
            r_dmem_re     <= 1'b0;
            r_imem_re     <= 1'b0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_eod         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_request_select != 6'h3F) begin
                        r_id        <= i_request_select;
                        r_reg_addr  <= i_request_select[4:0];
                        r_dmem_addr <= i_mem_addr;
                        r_imem_addr <= i_instr_addr;
                        r_reg_re    <= w_req_reg;
                        r_dmem_re   <= w_req_dmem;
                        r_imem_re   <= w_req_imem;
                        r_busy      <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_reg_re  <= 1'b0;
                    r_dmem_re <= 1'b0;
                    r_imem_re <= 1'b0;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_id_valid) begin
                        r_buf         <= w_load;
                        r_frame       <= w_load[NB_FRAME-1:0];
                        r_frame_valid <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= S_STREAM;
                    end else begin
                        r_eod   <= 1'b1;
                        r_state <= S_EOD;
                    end
                end
                S_STREAM: begin
                    if (r_cnt == NB_CNT'(NB_STRIP_WORDS-1)) begin
                        r_cnt         <= '0;
                        r_frame       <= '0;
                        r_frame_valid <= 1'b0;
                        r_eod         <= 1'b1;
                        r_state       <= S_EOD;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_buf   <= r_buf >> NB_FRAME;
                        r_frame <= r_buf[2*NB_FRAME-1:NB_FRAME];
                    end
                end
                S_EOD: begin
                    r_eod   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_reg_addr    = r_reg_addr;
    assign o_reg_re      = r_reg_re;
    assign o_dmem_addr   = r_dmem_addr;
    assign o_dmem_re     = r_dmem_re;
    assign o_imem_addr   = r_imem_addr;
    assign o_imem_re     = r_imem_re;
    assign o_frame       = r_frame;
    assign o_frame_valid = r_frame_valid;
    assign o_eod         = r_eod;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_debug_readout_sequencer.sv
// Directed bench for debug_readout_sequencer; expected frames are queued
// at request time and popped as the strip streams out.
module tb_debug_readout_sequencer;

    localparam int NB_FRAME = 32;
    localparam int NB_LG    = 3 * NB_FRAME;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic [5:0]            i_request_select;
    logic [15:0]           i_mem_addr;
    logic [8:0]            i_instr_addr;
    logic [4:0]            o_reg_addr;
    logic                  o_reg_re;
    logic [31:0]           i_reg_data;
    logic [15:0]           o_dmem_addr;
    logic                  o_dmem_re;
    logic [31:0]           i_dmem_data;
    logic [8:0]            o_imem_addr;
    logic                  o_imem_re;
    logic [31:0]           i_imem_data;
    logic [31:0]           i_pc;
    logic [8*NB_LG-1:0]    i_latch_bus;
    logic [31:0]           o_frame;
    logic                  o_frame_valid;
    logic                  o_eod;
    logic                  o_busy;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    debug_readout_sequencer dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_request_select (i_request_select),
        .i_mem_addr       (i_mem_addr),
        .i_instr_addr     (i_instr_addr),
        .o_reg_addr       (o_reg_addr),
        .o_reg_re         (o_reg_re),
        .i_reg_data       (i_reg_data),
        .o_dmem_addr      (o_dmem_addr),
        .o_dmem_re        (o_dmem_re),
        .i_dmem_data      (i_dmem_data),
        .o_imem_addr      (o_imem_addr),
        .o_imem_re        (o_imem_re),
        .i_imem_data      (i_imem_data),
        .i_pc             (i_pc),
        .i_latch_bus      (i_latch_bus),
        .o_frame          (o_frame),
        .o_frame_valid    (o_frame_valid),
        .o_eod            (o_eod),
        .o_busy           (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_frame_valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected_frame", 32'(o_frame_valid), 32'd0);
            else chk("frame", o_frame, q.pop_front());
        end else begin
            chk("frame_zero", o_frame, 32'd0);
        end
    end

    // Presents id in the current cycle T, then checks cycles T+1..T+last+1.
    task automatic do_req(input logic [5:0] id, input int last,
                          input logic [2:0] stb, input logic [5:0] mid_id,
                          input logic [31:0] mid_pc);
        i_request_select = id;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            chk("busy", 32'(o_busy), 32'(c <= last));
            chk("eod", 32'(o_eod), 32'(c == last));
            chk("strobes", 32'({o_reg_re, o_dmem_re, o_imem_re}),
                32'((c == 1) ? stb : 3'b000));
            i_request_select = (c == 2) ? mid_id : 6'h3F;
            if (c == 2) i_pc = mid_pc;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        i_reset          = 1'b1;
        i_request_select = 6'h3F;
        i_mem_addr       = '0;
        i_instr_addr     = '0;
        i_reg_data       = '0;
        i_dmem_data      = '0;
        i_imem_data      = '0;
        i_pc             = '0;
        for (int i = 0; i < 24; i++) i_latch_bus[i*32 +: 32] = $urandom;
        i_latch_bus[NB_LG-1:0]       = 96'h111111112222222233333333;
        i_latch_bus[2*NB_LG-1:NB_LG] = 96'hAAAAAAAABBBBBBBBCCCCCCCC;
        repeat (3) @(negedge clk);
        chk("rst_frame", o_frame, 32'd0);
        chk("rst_valid", 32'(o_frame_valid), 32'd0);
        chk("rst_eod", 32'(o_eod), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_strobes", 32'({o_reg_re, o_dmem_re, o_imem_re}), 32'd0);
        chk("rst_addrs", 32'({o_reg_addr, o_dmem_addr, o_imem_addr}), 32'd0);
        i_reset = 1'b0;
        @(negedge clk);

        i_reg_data = 32'hDEADBEEF;
        q.push_back(32'hDEADBEEF); q.push_back(32'd0); q.push_back(32'd0);
        do_req(6'h05, 6, 3'b100, 6'h3F, i_pc);
        chk("reg_addr", 32'(o_reg_addr), 32'd5);

        q.push_back(32'h11111111); q.push_back(32'h22222222);
        q.push_back(32'h33333333);
        do_req(6'h24, 6, 3'b000, 6'h3F, i_pc);

        i_mem_addr  = 16'h0040;
        i_dmem_data = 32'hCAFE0001;
        q.push_back(32'hCAFE0001); q.push_back(32'd0); q.push_back(32'd0);
        do_req(6'h20, 6, 3'b010, 6'h3F, i_pc);
        chk("dmem_addr", 32'(o_dmem_addr), 32'h0040);

        i_instr_addr = 9'h1A5;
        i_imem_data  = 32'h0BADF00D;
        q.push_back(32'h0BADF00D); q.push_back(32'd0); q.push_back(32'd0);
        do_req(6'h21, 6, 3'b001, 6'h3F, i_pc);
        chk("imem_addr", 32'(o_imem_addr), 32'h1A5);

        do_req(6'h2C, 3, 3'b000, 6'h3F, i_pc);

        i_pc = 32'h00400000;
        q.push_back(32'h00400004); q.push_back(32'd0); q.push_back(32'd0);
        do_req(6'h22, 6, 3'b000, 6'h07, 32'h00400004);

        i_request_select = 6'h25;
        q.push_back(32'hAAAAAAAA); q.push_back(32'hBBBBBBBB);
        q.push_back(32'hCCCCCCCC);
        @(negedge clk);
        i_request_select = 6'h3F;
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        chk("abort_frame", o_frame, 32'd0);
        chk("abort_valid", 32'(o_frame_valid), 32'd0);
        chk("abort_eod", 32'(o_eod), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_addrs", 32'({o_reg_addr, o_dmem_addr, o_imem_addr}), 32'd0);
        i_reset = 1'b0;
        chk("abort_left", 32'(q.size()), 32'd1);
        q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_eod", 32'(o_eod), 32'd0);
            chk("abort_idle", 32'(o_busy), 32'd0);
        end

        i_reg_data = 32'h12345678;
        q.push_back(32'h12345678); q.push_back(32'd0); q.push_back(32'd0);
        do_req(6'h01, 6, 3'b100, 6'h3F, i_pc);
        chk("reg_addr2", 32'(o_reg_addr), 32'd1);

        i_reset          = 1'b1;
        i_request_select = 6'h05;
        @(negedge clk);
        i_reset          = 1'b0;
        i_request_select = 6'h3F;
        chk("rst_wins_busy", 32'(o_busy), 32'd0);
        chk("rst_wins_re", 32'(o_reg_re), 32'd0);
        @(negedge clk);
        chk("rst_wins_idle", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
